// File: rtl/iter_div.sv
// Iterative restoring radix-2 divider, 32/32 -> {quotient, remainder}.
// One quotient bit per clock; result pulse 32 edges after the joint accept.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | tready high, waiting for divisor and dividend together
// BUSY  | one trial-subtract step per edge, iter_cnt = step index
// DONE  | result registered, m_axis_dout_tvalid high for this cycle
module iter_div #(
  parameter int DIV_SIGNED = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  input  logic [31:0] s_axis_dividend_tdata,
  output logic        m_axis_dout_tvalid,
  output logic [63:0] m_axis_dout_tdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam bit SGN = (DIV_SIGNED != 0);

  state_t      state;
  logic [4:0]  iter_cnt;
  logic [63:0] work;
  logic [31:0] divisor_mag;
  logic [31:0] dividend_raw;
  logic        quot_neg;
  logic        rem_neg;
  logic        div_zero;

  logic        accept;
  logic        dvd_neg;
  logic        dvs_neg;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [32:0] top;
  logic        fits;
  logic [31:0] diff;
  logic [63:0] work_next;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] quot_res;
  logic [31:0] rem_res;
  logic [63:0] result;

  assign s_axis_divisor_tready  = (state == IDLE);
  assign s_axis_dividend_tready = (state == IDLE);

  assign accept = (state == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid && !flush;

  assign dvd_neg = SGN && s_axis_dividend_tdata[31];
  assign dvs_neg = SGN && s_axis_divisor_tdata[31];
  assign dvd_mag = dvd_neg ? (~s_axis_dividend_tdata + 32'd1) : s_axis_dividend_tdata;
  assign dvs_mag = dvs_neg ? (~s_axis_divisor_tdata + 32'd1) : s_axis_divisor_tdata;

  // The trial compare includes the bit shifted out of the remainder half,
  // so divisors with bit 31 set never lose a remainder bit.
  assign top       = work[63:31];
  assign fits      = (top >= {1'b0, divisor_mag});
  assign diff      = top[31:0] - divisor_mag;
  assign work_next = fits ? {diff, work[30:0], 1'b1} : {work[62:0], 1'b0};

  assign quot_mag = work_next[31:0];
  assign rem_mag  = work_next[63:32];
  assign quot_res = quot_neg ? (~quot_mag + 32'd1) : quot_mag;
  assign rem_res  = rem_neg ? (~rem_mag + 32'd1) : rem_mag;
  assign result   = div_zero ? {32'hFFFF_FFFF, dividend_raw} : {quot_res, rem_res};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= IDLE;
      iter_cnt           <= 5'd0;
      work               <= 64'd0;
      divisor_mag        <= 32'd0;
      dividend_raw       <= 32'd0;
      quot_neg           <= 1'b0;
      rem_neg            <= 1'b0;
      div_zero           <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= 64'd0;
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          iter_cnt <= 5'd0;
          if (accept) begin
            work         <= {32'd0, dvd_mag};
            divisor_mag  <= dvs_mag;
            dividend_raw <= s_axis_dividend_tdata;
            quot_neg     <= dvd_neg ^ dvs_neg;
            rem_neg      <= dvd_neg;
            div_zero     <= (s_axis_divisor_tdata == 32'd0);
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            state    <= IDLE;
            iter_cnt <= 5'd0;
          end else begin
            work     <= work_next;
            iter_cnt <= iter_cnt + 5'd1;
            if (iter_cnt == 5'd31) begin
              state              <= DONE;
              m_axis_dout_tdata  <= result;
              m_axis_dout_tvalid <= 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          iter_cnt <= 5'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div: a signed and an unsigned instance share the
// same stimulus and are checked against hand-computed results and timing.
module tb_iter_div;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        dvs_valid, dvd_valid;
  logic [31:0] dvs_data, dvd_data;

  logic        dvs_rdy_u, dvd_rdy_u, vld_u;
  logic        dvs_rdy_s, dvd_rdy_s, vld_s;
  logic [63:0] data_u, data_s;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] prev_u = 64'd0;
  logic [63:0] prev_s = 64'd0;

  always #5 clk = ~clk;

  iter_div #(.DIV_SIGNED(0)) u_divu (
    .clk(clk), .resetn(resetn), .flush(flush),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(dvs_rdy_u),
    .s_axis_divisor_tdata(dvs_data),
    .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(dvd_rdy_u),
    .s_axis_dividend_tdata(dvd_data),
    .m_axis_dout_tvalid(vld_u), .m_axis_dout_tdata(data_u)
  );

  iter_div #(.DIV_SIGNED(1)) u_divs (
    .clk(clk), .resetn(resetn), .flush(flush),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(dvs_rdy_s),
    .s_axis_divisor_tdata(dvs_data),
    .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(dvd_rdy_s),
    .s_axis_dividend_tdata(dvd_data),
    .m_axis_dout_tvalid(vld_s), .m_axis_dout_tdata(data_s)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] eu;
    logic [63:0] es;
  } vec_t;

  // dividend, divisor, expected unsigned {q,r}, expected signed {q,r}
  vec_t vecs [15] = '{
    '{32'd100,        32'd7,        {32'h0000000E, 32'h00000002}, {32'h0000000E, 32'h00000002}},
    '{32'hFFFFFFF9,   32'd2,        {32'h7FFFFFFC, 32'h00000001}, {32'hFFFFFFFD, 32'hFFFFFFFF}},
    '{32'd7,          32'hFFFFFFFE, {32'h00000000, 32'h00000007}, {32'hFFFFFFFD, 32'h00000001}},
    '{32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000}, {32'h80000000, 32'h00000000}},
    '{32'h12345678,   32'd0,        {32'hFFFFFFFF, 32'h12345678}, {32'hFFFFFFFF, 32'h12345678}},
    '{32'hFFFFFFFF,   32'hFFFFFFFF, {32'h00000001, 32'h00000000}, {32'h00000001, 32'h00000000}},
    '{32'hFFFFFFFF,   32'd1,        {32'hFFFFFFFF, 32'h00000000}, {32'hFFFFFFFF, 32'h00000000}},
    '{32'h7FFFFFFF,   32'h80000000, {32'h00000000, 32'h7FFFFFFF}, {32'h00000000, 32'h7FFFFFFF}},
    '{32'h80000000,   32'h80000001, {32'h00000000, 32'h80000000}, {32'h00000001, 32'hFFFFFFFF}},
    '{32'hFFFFFFFF,   32'h80000001, {32'h00000001, 32'h7FFFFFFE}, {32'h00000000, 32'hFFFFFFFF}},
    '{32'd0,          32'd5,        {32'h00000000, 32'h00000000}, {32'h00000000, 32'h00000000}},
    '{32'hFFFFFFFE,   32'hFFFFFFFF, {32'h00000000, 32'hFFFFFFFE}, {32'h00000002, 32'h00000000}},
    '{32'hDEADBEEF,   32'h00000010, {32'h0DEADBEE, 32'h0000000F}, {32'hFDEADBEF, 32'hFFFFFFFF}},
    '{32'h80000000,   32'd0,        {32'hFFFFFFFF, 32'h80000000}, {32'hFFFFFFFF, 32'h80000000}},
    '{32'd1000000,    32'd3,        {32'h00051615, 32'h00000001}, {32'h00051615, 32'h00000001}}
  };

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] rdy_all();
    return {dvs_rdy_u, dvd_rdy_u, dvs_rdy_s, dvd_rdy_s};
  endfunction

  // Called at a negedge; returns at the negedge after E34.
  task automatic run_op(input string tag, input vec_t v, input int pre, input bit junk);
    int first_u, first_s, pulses_u, pulses_s, rdy_busy;
    logic [63:0] res_u, res_s;
    first_u = 0; first_s = 0; pulses_u = 0; pulses_s = 0; rdy_busy = 0;
    res_u = 64'd0; res_s = 64'd0;
    dvd_data  = v.a;
    dvs_data  = v.b;
    dvd_valid = 1'b1;
    repeat (pre) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (pre > 0) chk({tag, " one_valid_idle"}, 64'(rdy_all()), 64'hF);
    dvs_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (junk) begin
      dvd_data = ~v.a;
      dvs_data = 32'd3;
    end else begin
      dvd_valid = 1'b0;
      dvs_valid = 1'b0;
    end
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (vld_u) begin
        pulses_u++;
        if (first_u == 0) first_u = k;
        res_u = data_u;
      end
      if (vld_s) begin
        pulses_s++;
        if (first_s == 0) first_s = k;
        res_s = data_s;
      end
      if (k <= 32 && rdy_all() != 4'h0) rdy_busy++;
      if (k == 31) begin
        chk({tag, " hold_busy_u"}, data_u, prev_u);
        chk({tag, " hold_busy_s"}, data_s, prev_s);
      end
      if (k == 32) begin
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
      end
      if (k == 33) chk({tag, " rdy_back"}, 64'(rdy_all()), 64'hF);
    end
    chk({tag, " lat_u"}, 64'(first_u), 64'd32);
    chk({tag, " lat_s"}, 64'(first_s), 64'd32);
    chk({tag, " pulses_u"}, 64'(pulses_u), 64'd1);
    chk({tag, " pulses_s"}, 64'(pulses_s), 64'd1);
    chk({tag, " rdy_busy"}, 64'(rdy_busy), 64'd0);
    chk({tag, " res_u"}, res_u, v.eu);
    chk({tag, " res_s"}, res_s, v.es);
    chk({tag, " hold_u"}, data_u, v.eu);
    chk({tag, " hold_s"}, data_s, v.es);
    prev_u = v.eu;
    prev_s = v.es;
  endtask

  initial begin
    int pulses;
    resetn    = 1'b0;
    flush     = 1'b0;
    dvs_valid = 1'b0;
    dvd_valid = 1'b0;
    dvs_data  = 32'd0;
    dvd_data  = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy", 64'(rdy_all()), 64'hF);
    chk("rst_vld", 64'({vld_u, vld_s}), 64'd0);
    chk("rst_data_u", data_u, 64'd0);
    chk("rst_data_s", data_s, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++)
      run_op($sformatf("v%0d", i), vecs[i], (i == 1) ? 5 : 0, i == 3);

    // Abort at E10: no pulse, output data untouched.
    dvd_data = 32'd50; dvs_data = 32'd5;
    dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_rdy", 64'(rdy_all()), 64'hF);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (vld_u || vld_s) pulses++;
    end
    chk("flush_no_pulse", 64'(pulses), 64'd0);
    chk("flush_data_u", data_u, prev_u);
    chk("flush_data_s", data_s, prev_s);

    // flush in IDLE blocks a coincident accept.
    dvd_valid = 1'b1; dvs_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush_idle_rdy", 64'(rdy_all()), 64'hF);
    dvd_valid = 1'b0; dvs_valid = 1'b0; flush = 1'b0;

    run_op("after_flush", vecs[12], 0, 1'b0);

    // Reset mid-BUSY: outputs clear, nothing follows.
    dvd_data = 32'd99; dvs_data = 32'd4;
    dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_rdy", 64'(rdy_all()), 64'hF);
    chk("midrst_data_u", data_u, 64'd0);
    chk("midrst_data_s", data_s, 64'd0);
    prev_u = 64'd0;
    prev_s = 64'd0;
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (vld_u || vld_s) pulses++;
    end
    chk("midrst_no_pulse", 64'(pulses), 64'd0);

    run_op("after_rst", vecs[2], 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 Parameter: DIV_SIGNED, default 1, 1 = two's-complement divide (div), 0 = unsigned divide (divu).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset is asynchronous and active-low.
REQ-004 flush  input  1  synchronous abort of any in-flight operation.
REQ-005 s_axis_divisor_tvalid  input  1  divisor offered.
REQ-006 s_axis_divisor_tready  output  1  divisor can be accepted.
REQ-007 s_axis_divisor_tdata  input  32  divisor.
REQ-008 s_axis_dividend_tvalid  input  1  dividend offered.
REQ-009 s_axis_dividend_tready  output  1  dividend can be accepted.
REQ-010 s_axis_dividend_tdata  input  32  dividend.
REQ-011 m_axis_dout_tvalid  output  1  one-cycle result-valid pulse; no back-pressure input.
REQ-012 m_axis_dout_tdata  output  64  {quotient[63:32], remainder[31:0]}.

Function
REQ-013 Three states SHALL exist: IDLE, BUSY, DONE; a 5-bit iteration counter SHALL track BUSY progress.
REQ-014 Both tready outputs SHALL be high exactly when state is IDLE, and low in BUSY and DONE.
REQ-015 Accept SHALL occur on an edge where state is IDLE and both tvalid inputs are high; one tvalid alone SHALL be ignored, with nothing captured.
REQ-016 On accept, the operands SHALL be latched; in signed mode, magnitudes and the two result signs SHALL also be latched; state SHALL go to BUSY with counter 0.
REQ-017 BUSY SHALL perform one restoring radix-2 step per edge: shift the 64-bit partial remainder left, trial-subtract the 32-bit divisor magnitude, set the quotient bit.
REQ-018 After the step with counter 31, state SHALL go to DONE; the counter SHALL not wrap back into BUSY.
REQ-019 Latency: for an accept at edge E0, iterations SHALL occur at E1..E32, m_axis_dout_tvalid SHALL be high for exactly the cycle between E32 and E33, and state SHALL return to IDLE at E33.
REQ-020 m_axis_dout_tdata SHALL update at E32 and hold until the next result; it SHALL not change during BUSY.
REQ-021 In signed mode, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-023 Divide by zero, either mode, SHALL give quotient 0xFFFFFFFF and remainder equal to the raw dividend, with the same 33-cycle latency.
REQ-024 flush high at any edge in BUSY or DONE SHALL force IDLE, suppress or cancel tvalid from the next cycle, and leave tdata unchanged.
REQ-025 flush high in IDLE, coincident with valid operands, SHALL block the accept.
REQ-026 Operands presented during BUSY or DONE SHALL be ignored; new operands SHALL be accepted no earlier than E33.
REQ-027 Quotient and remainder SHALL be computed to full 32-bit width with no truncation in the 64-bit working register.

Reset
REQ-028 resetn low SHALL, asynchronously, set state to IDLE, the counter to 0, m_axis_dout_tvalid to 0, and m_axis_dout_tdata to 0.
REQ-029 Both tready outputs SHALL read 1 while resetn is low; tready SHALL be reported combinationally from state IDLE.
REQ-030 resetn asserted mid-BUSY SHALL abort the operation, and no tvalid SHALL follow deassertion.

Verification
REQ-031 Unsigned, 100 / 7, accept at E0 -> tvalid only in cycle E32-E33, tdata = {0x0000000E, 0x00000002}; tready low E0..E33.
REQ-032 Signed, -7 / 2 -> {0xFFFFFFFD, 0xFFFFFFFF}; signed, 7 / -2 -> {0xFFFFFFFD, 0x00000001}.
REQ-033 Signed, 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0x00000000}; either mode, 0x12345678 / 0 -> {0xFFFFFFFF, 0x12345678}.
REQ-034 Dividend tvalid only, for 5 cycles, then both -> no accept until both are high; latency is counted from the joint accept.
REQ-035 flush at E10 after accept -> IDLE at E10, tready high after E10, no tvalid pulse; a new op then completes normally with a correct result.
REQ-036 Random 10k operand pairs per mode, including 0, 1, -1, 0x7FFFFFFF, 0x80000000 -> every result matches the reference model and every latency is exactly 32 edges to tvalid.
